// File: rtl/fifo_xfer_pkg.sv
// Shared types and default sizing for the feature-buffer transfer sequencer.
package fifo_xfer_pkg;

  localparam int DW_DEF      = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XFER = 3'd1,
    DUMP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/xfer_buf.sv
// DEPTH x DW register array: one synchronous write port, one combinational
// read port. Contents are not reset; they are only meaningful after a load.
module xfer_buf
  import fifo_xfer_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // single write port, no reset on the storage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_xfer_ctrl.sv
// Transfer sequencer: load a block into src, push it through the external
// FIFO while draining the FIFO into dst, then replay dst on port_D.
//
//   state | meaning
//   IDLE  | accept loads into src; wait for s_sig with a full block
//   XFER  | write src into FIFO and read FIFO into dst concurrently
//   DUMP  | replay dst on port_D, one word per cycle
//   DONE  | one-cycle wrap-up; counters cleared on the way back to IDLE
//   ERR   | watchdog tripped; strobes held low until s_sig
module fifo_xfer_ctrl
  import fifo_xfer_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CW      = $clog2(DEPTH) + 1,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] port_A,
  input  logic          W_en,
  input  logic          s_sig,
  input  logic          R_en,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_wfull,
  input  logic          fifo_rempty,
  output logic [DW-1:0] fifo_wdata,
  output logic          fifo_winc,
  output logic          fifo_rinc,
  output logic [DW-1:0] port_D,
  output logic          port_D_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C    = CW'(DEPTH - 1);
  localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT);

  xfer_state_t state, next_state;

  logic [CW-1:0] load_cnt;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] out_cnt;
  logic [SW-1:0] stall_cnt;

  logic          load_full;
  logic          load_we;
  logic          clr_cnt;
  logic          xfer_entry;
  logic [DW-1:0] src_rdata;
  logic [DW-1:0] dst_rdata;

  assign load_full  = (load_cnt == DEPTH_C);
  assign load_we    = (state == IDLE) && W_en && !load_full && !rst;
  // DONE always returns to IDLE; ERR leaves only on s_sig and forces a reload
  assign clr_cnt    = (state == DONE) || ((state == ERR) && s_sig);
  assign xfer_entry = (state == IDLE) && (next_state == XFER);

  // Strobes are the only input-to-output paths; rst gates them so nothing
  // reaches the FIFO during the reset cycle.
  assign fifo_winc  = (state == XFER) && (wr_cnt < DEPTH_C) && !fifo_wfull && !rst;
  assign fifo_rinc  = (state == XFER) && (rd_cnt < DEPTH_C) && R_en && !fifo_rempty && !rst;
  assign fifo_wdata = src_rdata;

  assign busy = (state != IDLE);

  xfer_buf #(.DW(DW), .DEPTH(DEPTH)) u_src (
    .clk   (clk),
    .we    (load_we),
    .waddr (load_cnt[AW-1:0]),
    .wdata (port_A),
    .raddr (wr_cnt[AW-1:0]),
    .rdata (src_rdata)
  );

  xfer_buf #(.DW(DW), .DEPTH(DEPTH)) u_dst (
    .clk   (clk),
    .we    (fifo_rinc),
    .waddr (rd_cnt[AW-1:0]),
    .wdata (fifo_rdata),
    .raddr (out_cnt[AW-1:0]),
    .rdata (dst_rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // next-state decode; a completed read side wins over a same-cycle watchdog hit
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (s_sig && load_full)          next_state = XFER;
      XFER: if (rd_cnt == DEPTH_C)            next_state = DUMP;
            else if (stall_cnt == TIMEOUT_C)  next_state = ERR;
      DUMP: if (out_cnt == LAST_C)            next_state = DONE;
      DONE:                                   next_state = IDLE;
      ERR:  if (s_sig)                        next_state = IDLE;
      default:                                next_state = IDLE;
    endcase
  end

  // block counters: each stops at DEPTH because its strobe is gated there
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
    end else if (clr_cnt) begin
      load_cnt <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      if (load_we)         load_cnt <= load_cnt + 1'b1;
      if (fifo_winc)       wr_cnt   <= wr_cnt + 1'b1;
      if (fifo_rinc)       rd_cnt   <= rd_cnt + 1'b1;
      if (state == DUMP)   out_cnt  <= out_cnt + 1'b1;
    end
  end

  // stall watchdog: counts XFER cycles since the last read, R_en notwithstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (xfer_entry || fifo_rinc) begin
      stall_cnt <= '0;
    end else if ((state == XFER) && (stall_cnt != TIMEOUT_C)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // registered outputs; done lands one cycle after the last replayed word
  always_ff @(posedge clk) begin
    if (rst) begin
      port_D       <= '0;
      port_D_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      port_D_valid <= (state == DUMP);
      if (state == DUMP) port_D <= dst_rdata;
      done         <= (state == DONE);
      err          <= (next_state == ERR);
    end
  end

endmodule

// File: tb/tb_fifo_xfer_ctrl.sv
// Directed bench for fifo_xfer_ctrl with a behavioural FWFT FIFO
// (two-stage pointer synchronisers, selectable capacity).
module tb_fifo_xfer_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] port_A = '0;
  logic          W_en = 1'b0;
  logic          s_sig = 1'b0;
  logic          R_en = 1'b0;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_wfull;
  logic          fifo_rempty;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_winc;
  logic          fifo_rinc;
  logic [DW-1:0] port_D;
  logic          port_D_valid;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_xfer_ctrl #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .port_A       (port_A),
    .W_en         (W_en),
    .s_sig        (s_sig),
    .R_en         (R_en),
    .fifo_rdata   (fifo_rdata),
    .fifo_wfull   (fifo_wfull),
    .fifo_rempty  (fifo_rempty),
    .fifo_wdata   (fifo_wdata),
    .fifo_winc    (fifo_winc),
    .fifo_rinc    (fifo_rinc),
    .port_D       (port_D),
    .port_D_valid (port_D_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // behavioural FIFO, reset from rst like the real fifo1 (wrst_n = rrst_n = !rst)
  int            fifo_depth = 16;
  logic [DW-1:0] fmem [16];
  int            wptr = 0, rptr = 0;
  int            wptr_s1 = 0, wptr_s2 = 0, rptr_s1 = 0, rptr_s2 = 0;

  always @(posedge clk) begin
    if (rst) begin
      wptr <= 0; rptr <= 0;
      wptr_s1 <= 0; wptr_s2 <= 0; rptr_s1 <= 0; rptr_s2 <= 0;
    end else begin
      if (fifo_winc) begin
        fmem[wptr[3:0]] <= fifo_wdata;
        wptr <= wptr + 1;
      end
      if (fifo_rinc) rptr <= rptr + 1;
      wptr_s1 <= wptr; wptr_s2 <= wptr_s1;
      rptr_s1 <= rptr; rptr_s2 <= rptr_s1;
    end
  end

  assign fifo_wfull  = ((wptr - rptr_s2) >= fifo_depth);
  assign fifo_rempty = (wptr_s2 == rptr);
  assign fifo_rdata  = fmem[rptr[3:0]];

  // strobe monitors, sampled on the pre-edge values
  int winc_total = 0, rinc_total = 0, wfull_viol = 0;
  always @(posedge clk) begin
    if (!rst && fifo_winc) winc_total <= winc_total + 1;
    if (!rst && fifo_rinc) rinc_total <= rinc_total + 1;
    if (!rst && fifo_winc && fifo_wfull) wfull_viol <= wfull_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; W_en = 1'b0; s_sig = 1'b0; R_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      W_en = 1'b1;
      port_A = base + 8'(i);
      @(negedge clk);
    end
    W_en = 1'b0;
  endtask

  task automatic pulse_start();
    s_sig = 1'b1;
    @(negedge clk);
    s_sig = 1'b0;
  endtask

  // follow a run to done and check the replayed block against base+i
  task automatic run_check(input logic [7:0] base, input string tag);
    int nv, first_v, last_v, done_at, w0, r0;
    logic [7:0] got [DEPTH];
    nv = 0; first_v = -1; last_v = -1; done_at = -1;
    w0 = winc_total; r0 = rinc_total;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      if (port_D_valid) begin
        if (nv < DEPTH) got[nv] = port_D;
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (done) begin
        done_at = c;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, done_at >= 0, 1);
    chk({tag, "_nvalid"}, nv, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_word%0d", tag, i), got[i], base + 8'(i));
    chk({tag, "_consecutive"}, last_v - first_v + 1, DEPTH);
    chk({tag, "_done_after_last"}, done_at, last_v + 1);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_winc_total"}, winc_total - w0, DEPTH);
    chk({tag, "_rinc_total"}, rinc_total - r0, DEPTH);
    chk({tag, "_wfull_viol"}, wfull_viol, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int r0;
    // reset values
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", port_D_valid, 0);
    chk("rst_portD", port_D, 0);
    chk("rst_winc", fifo_winc, 0);
    chk("rst_rinc", fifo_rinc, 0);
    rst = 1'b0;

    // basic run, deep FIFO
    R_en = 1'b1;
    load(8'h00, 16);
    pulse_start();
    chk("t1_first_wr", fifo_winc, 1);
    chk("t1_busy", busy, 1);
    run_check(8'h00, "t1");

    // shallow FIFO forces wfull back-pressure
    fifo_depth = 4;
    load(8'h00, 16);
    pulse_start();
    chk("t2_first_wr", fifo_winc, 1);
    run_check(8'h00, "t2");
    fifo_depth = 16;

    // start with partial block is ignored
    load(8'h40, 10);
    begin
      int w0;
      w0 = winc_total;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
        chk("t3_idle_busy", busy, 0);
        @(negedge clk);
      end
      chk("t3_no_winc", winc_total - w0, 0);
    end
    load(8'h4A, 6);
    pulse_start();
    chk("t3_first_wr", fifo_winc, 1);
    run_check(8'h40, "t3");

    // paused reader trips the watchdog
    R_en = 1'b0;
    load(8'h50, 16);
    pulse_start();
    for (int k = 1; k <= 70; k++) begin
      if (k == 65) chk("t4_err_before", err, 0);
      if (k == 66) begin
        chk("t4_err_set", err, 1);
        chk("t4_err_winc", fifo_winc, 0);
        chk("t4_err_rinc", fifo_rinc, 0);
        chk("t4_err_busy", busy, 1);
      end
      @(negedge clk);
    end
    R_en = 1'b1;
    #1;
    chk("t4_err_rinc_held", fifo_rinc, 0);
    chk("t4_err_sticky", err, 1);
    @(negedge clk);
    pulse_start();
    chk("t4_exit_err", err, 0);
    chk("t4_exit_busy", busy, 0);
    pulse_start();
    chk("t4_needs_reload", busy, 0);
    do_reset();

    // reset in the middle of the transfer, at rd_cnt == 7
    R_en = 1'b1;
    load(8'h60, 16);
    r0 = rinc_total;
    pulse_start();
    for (int c = 0; c < 100 && (rinc_total - r0) < 7; c++) @(negedge clk);
    chk("t5_reached_rd7", rinc_total - r0, 7);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_winc", fifo_winc, 0);
    chk("t5_rst_rinc", fifo_rinc, 0);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_valid", port_D_valid, 0);
    chk("t5_portD", port_D, 0);
    rst = 1'b0;
    @(negedge clk);

    // 17th load word is discarded
    load(8'hA0, 17);
    pulse_start();
    chk("t6_first_wr", fifo_winc, 1);
    run_check(8'hA0, "t6");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_xfer_ctrl.md
# fifo_xfer_ctrl

Single-clock transfer sequencer for the feature-buffer path. It captures a DEPTH-word block from `port_A` into a local source buffer, then streams it into an external `fifo1` instance while draining the FIFO into a local destination buffer. It then replays the destination buffer on `port_D` and pulses `done`. It replaces the ad-hoc index/flag logic around the FIFO with one FSM, explicit counters and a stall watchdog.

## Interface
- `DW`, 8, data width (matches FIFO `wdata`/`rdata`)
- `DEPTH`, 16, words per block (power of two)
- `CW`, $clog2(DEPTH)+1, counter width (must represent DEPTH itself)
- `TIMEOUT`, 64, max consecutive XFER cycles with no FIFO read before error
- `clk`  in  1  single clock; FIFO `wclk` and `rclk` are tied to it
- `rst`  in  1  synchronous, active-high reset
- `port_A`  in  DW  load data
- `W_en`  in  1  load strobe; one word captured per cycle
- `s_sig`  in  1  start request
- `R_en`  in  1  read permit; when low, FIFO reads pause
- `fifo_rdata`  in  DW  FIFO read data (first-word-fall-through)
- `fifo_wfull`  in  1  FIFO full
- `fifo_rempty`  in  1  FIFO empty
- `fifo_wdata`  out  DW  FIFO write data
- `fifo_winc`  out  1  FIFO write strobe
- `fifo_rinc`  out  1  FIFO read strobe
- `port_D`  out  DW  replay data
- `port_D_valid`  out  1  `port_D` qualifier
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky watchdog error

## Operation
- States:
  - IDLE→XFER: on `s_sig` with `load_cnt==DEPTH`.
  - XFER→DUMP: when `rd_cnt==DEPTH`.
  - XFER→ERR: when the stall counter reaches TIMEOUT.
  - DUMP→DONE: after DEPTH words.
  - DONE→IDLE: unconditionally.
  - ERR→IDLE: on `s_sig`.
- IDLE:
  - `W_en && load_cnt<DEPTH` writes `src[load_cnt]<=port_A` and increments `load_cnt`.
  - `W_en` at `load_cnt==DEPTH` is ignored; there is no overwrite.
  - `s_sig` with `load_cnt<DEPTH` is ignored.
- XFER write side:
  - `fifo_winc = (state==XFER) && wr_cnt<DEPTH && !fifo_wfull && !rst`.
  - `fifo_wdata = src[wr_cnt]`.
  - `wr_cnt` increments on each `fifo_winc`.
- XFER read side:
  - `fifo_rinc = (state==XFER) && rd_cnt<DEPTH && R_en && !fifo_rempty && !rst`.
  - On the same edge, `dst[rd_cnt]<=fifo_rdata` and `rd_cnt` increments.
  - Read and write proceed concurrently in the same cycle.
- Stall counter:
  - Clears on every `fifo_rinc` and on XFER entry.
  - Otherwise increments while in XFER, saturating at TIMEOUT.
  - `R_en` low does not suppress it: a paused reader can trip the watchdog.
- DUMP: each cycle registers `port_D<=dst[out_cnt]` and `port_D_valid<=1`, for out_cnt 0..DEPTH-1.
- DONE:
  - `done=1` for one cycle.
  - `load_cnt`, `wr_cnt`, `rd_cnt`, `out_cnt` are cleared on the DONE→IDLE transition.
  - `src`/`dst` contents are retained.
- ERR:
  - `err<=1`; the FIFO strobes are held low.
  - Leaving ERR on `s_sig` clears `err` and all counters, including `load_cnt`, so a reload is required.
  - FIFO residue is not flushed; the integrator pulses FIFO resets.
- Boundaries:
  - `fifo_wfull` stalls writes without losing words.
  - `fifo_rempty` stalls reads.
  - Counters never exceed DEPTH; there is no wrap.
  - `s_sig` outside IDLE/ERR is ignored.

## Timing
- Reset (`rst` high at an edge) sets:
  - state=IDLE and all counters 0;
  - `fifo_winc`=`fifo_rinc`=0 combinationally during the reset cycle;
  - `port_D`=0, `port_D_valid`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-transfer aborts with the same values. Buffer contents are undefined.
- `busy`, `done`, `err` and `port_D_valid` are decoded or registered from state with no combinational input path.
- `fifo_winc`/`fifo_rinc` depend combinationally on `fifo_wfull`/`fifo_rempty`/`R_en`. This is the only input-to-output path.
- Latency with an unobstructed FIFO (synchronizer delay S cycles, typically 2):
  - first write the cycle after `s_sig` is sampled;
  - first read about S+1 cycles later;
  - DUMP lasts DEPTH cycles;
  - `done` follows the last `port_D_valid` by one cycle.

## Structure
- A shared package `fifo_xfer_pkg` holds:
  - the state enum (IDLE, XFER, DUMP, DONE, ERR);
  - default DW/DEPTH/TIMEOUT constants.
- One sub-module, `xfer_buf`: a DEPTH×DW register array with one write port and a combinational read port. Instantiate it twice, for `src` and `dst`.
- The FSM, counters and watchdog live in the top.
- The `fifo1` instance stays outside this block. Bench and integration connect it, with `wrst_n`/`rrst_n` driven from `!rst`.

## Test plan
- Load 0x00..0x0F with `W_en` for 16 cycles, pulse `s_sig`, hold `R_en=1`, FIFO depth 16 → `port_D` shows 0x00..0x0F in order on 16 consecutive valid cycles, then `done` for 1 cycle and `busy` low.
- Same load, with a FIFO of address width 2 (4 entries) → `fifo_winc` drops whenever `wfull` is high, no word lost or duplicated, `port_D` still shows 0x00..0x0F.
- Pulse `s_sig` after only 10 loads → stays IDLE, `fifo_winc` never asserts. After 6 more loads, `s_sig` starts XFER.
- Hold `R_en=0` for 70 cycles after start → `err` asserts at TIMEOUT=64 stall cycles and strobes go low. Then `s_sig` returns to IDLE with `err=0` and `load_cnt=0`.
- Assert `rst` for 1 cycle at `rd_cnt=7` → next cycle: IDLE, `fifo_winc`=`fifo_rinc`=0 during the reset cycle, all outputs at reset values.
- 17 `W_en` pulses with data 0xA0..0xB0 → `src` holds 0xA0..0xAF, 0xB0 discarded (visible via `port_D` after a full run).
